// File: rtl/stream_pkg.sv
// Shared stream definitions: holding-register state and default widths.
package stream_pkg;

    // EMPTY: no beat held; HOLD: one beat waiting for its successor or a flush.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/conv_first_to_last_ready.sv
// First-framed to last-framed stream converter. One beat is held back until
// the next beat (whose first flag tells whether the held beat ended a packet)
// or a flush arrives, so the held beat can be emitted with a correct last.
module conv_first_to_last_ready
    import stream_pkg::*;
#(
    parameter int width     = DEFAULT_WIDTH,
    parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 up_first,
    input  logic [width-1:0]     up_data,
    input  logic                 up_flush,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic                 down_last,
    output logic [width-1:0]     down_data,
    output logic [cnt_width-1:0] pkt_count,
    output logic                 proto_error
);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             fire_dn;
    logic             start_err;
    logic [width-1:0] held_data;

    // State register for the EMPTY/HOLD controller.
    // NOTE: every clocked block uses non-blocking (<=) so all registers update
    // from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and load strobe.
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        down_valid = 1'b0;
        down_last  = 1'b0;
        up_ready   = 1'b1;
        fire_dn    = 1'b0;
        load       = 1'b0;
        start_err  = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                // Nothing held: accept any beat; flush alone has no effect.
                up_ready = 1'b1;
                if (up_valid) begin
                    load       = 1'b1;
                    start_err  = ~up_first;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // An incoming beat takes priority over flush for the last flag.
                down_valid = up_valid | up_flush;
                down_last  = up_valid ? up_first : 1'b1;
                fire_dn    = down_valid & down_ready;
                up_ready   = fire_dn;
                if (fire_dn) begin
                    if (up_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Holding register for the delayed beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_data <= '0;
        end else if (load) begin
            held_data <= up_data;
        end
    end

    // Packet counter (wraps naturally) and sticky start-of-stream error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_count   <= '0;
            proto_error <= 1'b0;
        end else begin
            if (fire_dn && down_last) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (start_err) begin
                proto_error <= 1'b1;
            end
        end
    end

    assign down_data = held_data;

endmodule

// File: doc/conv_first_to_last_ready.md
Name: conv_first_to_last_ready

Overview:
- Streaming converter: upstream marks packet start with up_first; downstream needs packet end marked with down_last.
- Holds one beat in a register. Emits it when the next beat arrives, whose up_first decides the held beat's last flag, or when an explicit flush closes the stream.
- Full valid/ready handshake on both sides, plus a sticky protocol-error flag and a packet counter.
- Sits between a first-framed source (parser, DMA reader) and a last-framed sink (AXI-Stream style consumer).

Parameters:
- width, 8, data width in bits.
- cnt_width, 16, width of the packet counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- up_valid  input  1  upstream beat present.
- up_ready  output  1  upstream beat accepted when up_valid & up_ready.
- up_first  input  1  beat is first of a packet.
- up_data  input  width  beat payload.
- up_flush  input  1  level request: close the stream and emit the held beat as last.
- down_valid  output  1  downstream beat present.
- down_ready  input  1  downstream accepts when down_valid & down_ready.
- down_last  output  1  beat is last of a packet.
- down_data  output  width  beat payload (held register).
- pkt_count  output  cnt_width  number of packets emitted (count of down beats with last).
- proto_error  output  1  sticky; a stream began without up_first.

Behaviour:
- Interface: one clock (clock); asynchronous active-high reset (reset).
- State: held_valid (1), held_data (width), pkt_count, proto_error. Two states:
  - EMPTY: held_valid = 0.
  - HOLD: held_valid = 1.
- Reset (asynchronous, any time including mid-packet):
  - held_valid = 0, held_data = 0, pkt_count = 0, proto_error = 0.
  - The held beat is discarded; no last is emitted.
  - Outputs during and after reset: down_valid = 0, down_last = 0, down_data = 0, up_ready = 1.
- Combinational outputs:
  - down_valid = held_valid & (up_valid | up_flush).
  - down_last = up_valid ? up_first : 1. Both are 0 when held_valid = 0.
  - down_data = held_data.
  - up_ready = ~held_valid | (down_valid & down_ready).
  - Combinational paths up_valid/up_first to down_valid/down_last and down_ready to up_ready are permitted; integrators must not close a loop through them.
- Transitions (fire_up = up_valid & up_ready; fire_dn = down_valid & down_ready):
  - EMPTY & fire_up: held_data <= up_data; go to HOLD. If up_first = 0, proto_error <= 1; the beat is still stored.
  - HOLD & up_valid & fire_dn: emit held beat with last = up_first; load the new beat; stay in HOLD.
  - HOLD & ~up_valid & up_flush & fire_dn: emit held beat with last = 1; go to EMPTY.
  - HOLD & down_ready = 0: nothing moves; held_data stable; up_ready = 0.
  - EMPTY & up_flush: no effect.
- Priority: when up_valid and up_flush are both high, up_valid wins. Flush takes effect only in a cycle with no upstream beat. The source keeps up_flush high until it sees down_last & fire_dn with up_valid low.
- Latency: a beat leaves in the same cycle as its successor or flush is accepted (one-beat delay in beat count, zero extra cycles).
- pkt_count increments by 1 on every fire_dn with down_last = 1 and wraps modulo 2^cnt_width.
- proto_error clears only on reset.
- Single-beat packets (consecutive up_first = 1) produce down_last = 1 on every beat.
- Throughput: one beat per cycle while down_ready = 1 and up_valid = 1.

Decomposition:
- Shared stream package (stream_pkg): state enum (ST_EMPTY, ST_HOLD) and the default-width constant.
- No sub-module needed; the holding register, control and counter fit in one module.

Test Plan:
- Reset, then beats A (first=1), B (first=0), C (first=1), D (first=0), then flush; down_ready = 1 → out A/last0, B/last1, C/last0, D/last1; pkt_count = 2; proto_error = 0.
- Three single-beat packets 0x11, 0x22, 0x33 (all first=1) then flush → all three out with last=1; pkt_count = 3.
- Hold down_ready = 0 for 5 cycles with HOLD and up_valid = 1 → up_ready = 0; down_data stable; after release, the stalled beat emits once with correct last and no beat is lost.
- First beat after reset has first=0 (data 0x5A) → proto_error = 1 and stays 1; data still passes; flush → 0x5A with last=1.
- up_valid and up_flush high together (held 0x01, incoming 0x02 first=0) → 0x01 out with last=0; then flush alone → 0x02 with last=1.
- Assert reset asynchronously mid-packet while in HOLD → down_valid = 0 immediately; pkt_count = 0; next stream starts clean.
